launch_sequencer: RTL

Sequences one complete shot in running (non-maintenance) mode: it slews the turntable servo to a commanded angle, waits a settle time proportional to the travel, fires the launcher servo, retracts it, and reports completion. It sits between the serial instruction decoder and the two servo drivers. It owns their enable and 8-bit position inputs whenever the decoder's mode bit selects running operation.

---
 rtl/launch_pkg.sv | 19 +
 rtl/settle_calc.sv | 37 +++
 rtl/launch_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/launch_pkg.sv
// Shared types and constants for the launch sequencer.
// Optional feature macro: LAUNCH_SEQ_QUEUE_EN (one-entry pending command).
package launch_pkg;

  localparam int CNT_W = 24;

  localparam logic [7:0] TT_HOME_DEF     = 8'd128;
  localparam logic [7:0] LAUNCH_REST_DEF = 8'd0;
  localparam logic [7:0] LAUNCH_FIRE_DEF = 8'd200;

  typedef enum logic [2:0] {
    IDLE,
    ROTATE,
    FIRE,
    RETRACT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/settle_calc.sv
// Turntable settle time: base plus per-step cost of angle travel.
// Saturates at the counter width so long moves never wrap short.
module settle_calc
  import launch_pkg::*;
#(
  parameter int SETTLE_BASE     = 50_000,
  parameter int SETTLE_PER_STEP = 4_000
) (
  input  logic [7:0]       target,
  input  logic [7:0]       current,
  output logic [CNT_W-1:0] settle
);

  localparam logic [CNT_W-1:0] SAT  = '1;
  localparam logic [31:0]      BASE = 32'(SETTLE_BASE);
  localparam logic [31:0]      STEP = 32'(SETTLE_PER_STEP);
  localparam logic [CNT_W-1:0] BASE_SAT =
    (BASE > 32'(SAT)) ? SAT : BASE[CNT_W-1:0];

  logic [8:0]       travel;
  logic [47:0]      prod;
  logic [CNT_W-1:0] prod_sat;
  logic [CNT_W:0]   sum;

  // Magnitude of travel, scaled and saturated, then added to the base.
  always_comb begin
    if (target >= current)
      travel = {1'b0, target} - {1'b0, current};
    else
      travel = {1'b0, current} - {1'b0, target};
    prod     = 48'(travel) * 48'(STEP);
    prod_sat = (prod > 48'(SAT)) ? SAT : prod[CNT_W-1:0];
    sum      = {1'b0, BASE_SAT} + {1'b0, prod_sat};
    settle   = sum[CNT_W] ? SAT : sum[CNT_W-1:0];
  end

endmodule

// File: rtl/launch_sequencer.sv
// Shot sequencer: rotate turntable, settle, fire, retract, report.
// Optional feature macro: LAUNCH_SEQ_QUEUE_EN (one-entry pending command).
module launch_sequencer
  import launch_pkg::*;
#(
  parameter int         SETTLE_BASE     = 50_000,
  parameter int         SETTLE_PER_STEP = 4_000,
  parameter int         FIRE_HOLD       = 250_000,
  parameter logic [7:0] TT_HOME         = TT_HOME_DEF,
  parameter logic [7:0] LAUNCH_REST     = LAUNCH_REST_DEF,
  parameter logic [7:0] LAUNCH_FIRE     = LAUNCH_FIRE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_angle,
  output logic       cmd_ready,
  input  logic       abort,
  output logic       turntable_en,
  output logic [7:0] turntable_pos,
  output logic       launcher_en,
  output logic [7:0] launcher_pos,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(FIRE_HOLD - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tt_q, tt_d;
  logic [7:0]       lp_q, lp_d;
  logic             abt_q, abt_d;
  logic             launch_now;
  logic [7:0]       launch_angle;
  logic [CNT_W-1:0] settle;

`ifdef LAUNCH_SEQ_QUEUE_EN
  logic       qf_q, qf_d;
  logic [7:0] qa_q, qa_d;
  logic       pend;
  logic       store;

  assign cmd_ready    = !qf_q;
  assign pend         = qf_q && !abort &&
                        (state_q == DONE || state_q == IDLE);
  assign store        = cmd_valid && cmd_ready && state_q != IDLE;
  assign launch_now   = pend || (state_q == IDLE && cmd_valid && !qf_q);
  assign launch_angle = qf_q ? qa_q : cmd_angle;
`else
  assign cmd_ready    = (state_q == IDLE);
  assign launch_now   = (state_q == IDLE) && cmd_valid;
  assign launch_angle = cmd_angle;
`endif

  settle_calc #(
    .SETTLE_BASE     (SETTLE_BASE),
    .SETTLE_PER_STEP (SETTLE_PER_STEP)
  ) u_settle (
    .target  (launch_angle),
    .current (tt_q),
    .settle  (settle)
  );

  // State, counter, positions and pending command registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tt_q    <= TT_HOME;
      lp_q    <= LAUNCH_REST;
      abt_q   <= 1'b0;
`ifdef LAUNCH_SEQ_QUEUE_EN
      qf_q    <= 1'b0;
      qa_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      lp_q    <= lp_d;
      abt_q   <= abt_d;
`ifdef LAUNCH_SEQ_QUEUE_EN
      qf_q    <= qf_d;
      qa_q    <= qa_d;
`endif
    end
  end

  // Next-state: sequencing, abort handling and command launch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    lp_d    = lp_q;
    abt_d   = abt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (launch_now) begin
          state_d = ROTATE;
          tt_d    = launch_angle;
          cnt_d   = settle - 1'b1;
          abt_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ROTATE, FIRE: begin
        if (abort) begin
          state_d = RETRACT;
          lp_d    = LAUNCH_REST;
          cnt_d   = HOLD_M1;
          abt_d   = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = (state_q == ROTATE) ? FIRE : RETRACT;
          lp_d    = (state_q == ROTATE) ? LAUNCH_FIRE : LAUNCH_REST;
          cnt_d   = HOLD_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RETRACT: begin
        if (cnt_q == '0)
          state_d = abt_q ? IDLE : DONE;
        else
          cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LAUNCH_SEQ_QUEUE_EN
  // Pending command slot: filled while busy, drained on launch.
  always_comb begin
    qf_d = qf_q;
    qa_d = qa_q;
    if (abort) begin
      qf_d = 1'b0;
    end else if (pend) begin
      qf_d = 1'b0;
    end else if (store) begin
      qf_d = 1'b1;
      qa_d = cmd_angle;
    end
  end
`endif

  assign turntable_pos = tt_q;
  assign launcher_pos  = lp_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign turntable_en  = (state_q == ROTATE) ||
                         (state_q == FIRE) ||
                         (state_q == RETRACT);
  assign launcher_en   = (state_q == FIRE) ||
                         (state_q == RETRACT);

endmodule
